// File: rtl/lisnoc16_usb_arb.sv
// Packet-level round-robin arbiter for the lisnoc16 USB bridge NoC input.
// A grant is locked from header to tail; flits leave through a one-entry output register.
module lisnoc16_usb_arb #(
    parameter int ports      = 4,
    parameter int flit_width = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ports-1:0]            cfg_enable,
    input  logic [ports*flit_width-1:0] in_flit,
    input  logic [ports-1:0]            in_valid,
    output logic [ports-1:0]            in_ready,
    output logic [flit_width-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(ports)-1:0]    grant,
    output logic                        busy,
    output logic                        err_proto
);
    localparam int GW = $clog2(ports);

    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;

    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         win;
    logic                  found;
    int unsigned           arb_idx;
    logic [ports-1:0]      elig;
    logic [ports-1:0]      stall;
    logic                  stall_err;
    logic [flit_width-1:0] cur_flit;
    logic [1:0]            cur_type;
    logic                  xfer;
    logic                  pkt_open;
    logic                  pkt_end;
    logic                  proto_hit;
    logic [3:0]            stall_cnt [ports];

    // Type bit 0 set means header or single: only those may open a packet.
    always_comb begin
        elig  = '0;
        stall = '0;
        for (int unsigned i = 0; i < ports; i++) begin
            elig[i]  = in_valid[i] & cfg_enable[i] &  in_flit[i*flit_width + flit_width - 2];
            stall[i] = in_valid[i] & cfg_enable[i] & ~in_flit[i*flit_width + flit_width - 2];
        end
    end

    always_comb begin
        found   = 1'b0;
        win     = '0;
        arb_idx = 0;
        for (int unsigned k = 0; k < ports; k++) begin
            arb_idx = (32'(rr_ptr) + k) % ports;
            if (!found && elig[arb_idx]) begin
                found = 1'b1;
                win   = GW'(arb_idx);
            end
        end
    end

    always_comb begin
        stall_err = 1'b0;
        for (int unsigned i = 0; i < ports; i++) begin
            if (state == IDLE && stall[i] && stall_cnt[i] == 4'hF)
                stall_err = 1'b1;
        end
    end

    assign cur_flit = in_flit[int'(grant)*flit_width +: flit_width];
    assign cur_type = cur_flit[flit_width-1 -: 2];
    assign busy     = (state == LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // A header/single after the first flit is flagged but forwarded; it never ends the packet.
    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        xfer      = 1'b0;
        proto_hit = 1'b0;
        pkt_end   = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_nxt = LOCKED;
            end
            LOCKED: begin
                in_ready[grant] = !out_valid | out_ready;
                xfer            = in_valid[grant] & (!out_valid | out_ready);
                proto_hit       = xfer & pkt_open & cur_type[0];
                pkt_end         = xfer & cur_type[1] & !proto_hit;
                if (pkt_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            out_flit  <= '0;
            out_valid <= 1'b0;
            pkt_open  <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (state == IDLE && found) grant <= win;
            if (xfer) begin
                out_flit  <= cur_flit;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (pkt_end) begin
                pkt_open <= 1'b0;
                rr_ptr   <= (grant == GW'(ports - 1)) ? '0 : grant + 1'b1;
            end else if (xfer) begin
                pkt_open <= 1'b1;
            end
            if (proto_hit || stall_err) err_proto <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ports; i++) stall_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < ports; i++) begin
                if (state == IDLE && stall[i]) begin
                    if (stall_cnt[i] != 4'hF) stall_cnt[i] <= stall_cnt[i] + 4'd1;
                end else begin
                    stall_cnt[i] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_lisnoc16_usb_arb.sv
// Scoreboard bench for lisnoc16_usb_arb: a packet-level round-robin model predicts
// flit order and grants; a negedge monitor checks everything the DUT emits.
module tb_lisnoc16_usb_arb;
    localparam int P  = 4;
    localparam int FW = 18;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P-1:0]    cfg_enable = '1;
    logic [P*FW-1:0] in_flit = '0;
    logic [P-1:0]    in_valid = '0;
    logic [P-1:0]    in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      grant;
    logic            busy;
    logic            err_proto;

    lisnoc16_usb_arb #(.ports(P), .flit_width(FW)) u_dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .in_flit(in_flit),
        .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
        .out_valid(out_valid), .out_ready(out_ready), .grant(grant),
        .busy(busy), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    logic [17:0] pq [P][$];   // flits still to be offered by each requester
    logic [17:0] mq [P][$];   // model's view of packets not yet scheduled
    logic [17:0] exp_flit [$];
    int          exp_gnt [$];
    int          mdl_rr = 0;
    bit          hold [P];
    bit          wrap_arm = 0;
    int          or_mode = 0;
    int          cyc = 0;
    int          sent [P];
    int          n_checks = 0;
    int          n_pass = 0;
    int          mon_cyc = 0;
    int          xfer_cnt = 0;
    int          last_xfer = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, expv);
    endtask

    task automatic put(input int p, input logic [1:0] t, input logic [15:0] d);
        pq[p].push_back({t, d});
        mq[p].push_back({t, d});
    endtask

    task automatic add_pkt(input int p, input int len, input logic [15:0] d0, input bit rnd);
        logic [1:0]  t;
        logic [15:0] d;
        for (int j = 0; j < len; j++) begin
            t = (len == 1) ? 2'b11 : (j == 0) ? 2'b01 : (j == len - 1) ? 2'b10 : 2'b00;
            d = rnd ? 16'($urandom) : d0 + 16'(j);
            put(p, t, d);
        end
    endtask

    task automatic present();
        for (int p = 0; p < P; p++) begin
            in_valid[p]        = (pq[p].size() > 0) && !hold[p];
            in_flit[p*FW +: FW] = (pq[p].size() > 0) ? pq[p][0] : '0;
        end
    endtask

    // One whole packet of port p moves from the model queue to the expectations.
    task automatic take(input int p);
        logic [17:0] f;
        exp_gnt.push_back(p);
        do begin
            f = mq[p].pop_front();
            exp_flit.push_back(f);
        end while (mq[p].size() > 0 && f[17:16] != 2'b10 && f[17:16] != 2'b11);
    endtask

    task automatic go(input logic [3:0] m);
        int w;
        cfg_enable = m;
        w = 0;
        while (w >= 0) begin
            w = -1;
            for (int k = 0; k < P; k++) begin
                int q;
                q = (mdl_rr + k) % P;
                if (w < 0 && m[q] && mq[q].size() > 0) w = q;
            end
            if (w >= 0) begin
                take(w);
                mdl_rr = (w + 1) % P;
            end
        end
        present();
    endtask

    task automatic tick();
        logic [P-1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < P; p++) begin
            if (acc[p] && pq[p].size() > 0) begin
                void'(pq[p].pop_front());
                sent[p]++;
            end
        end
        if (wrap_arm && pq[3].size() == 1 && busy && grant == 2'd3) begin
            hold[0]  = 0;
            wrap_arm = 0;
        end
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        present();
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while ((exp_flit.size() > 0 || busy || out_valid) && i < 3000) begin
            tick();
            i++;
        end
        chk(nm, 32'(exp_flit.size() == 0 && exp_gnt.size() == 0 && !busy && !out_valid), 32'd1);
    endtask

    initial begin
        logic [17:0] pf;
        logic [31:0] e;
        bit          pstall;
        bit          pbusy;
        pstall = 0;
        pbusy  = 0;
        pf     = '0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rst) begin
                exp_flit.delete();
                exp_gnt.delete();
                pstall = 0;
                pbusy  = 0;
            end else begin
                if (pstall) chk("stall_hold", {out_valid, out_flit}, {1'b1, pf});
                if (!busy) chk("ready_idle", in_ready, 0);
                if (busy && !pbusy) begin
                    if (exp_gnt.size() > 0) e = exp_gnt.pop_front();
                    else                    e = 32'hDEAD_BEEF;
                    chk("grant", grant, e);
                end
                if (out_valid && out_ready) begin
                    if (exp_flit.size() > 0) e = 32'(exp_flit.pop_front());
                    else                     e = 32'hDEAD_BEEF;
                    chk("out_flit", out_flit, e);
                    xfer_cnt++;
                    last_xfer = mon_cyc;
                end
                pstall = out_valid && !out_ready;
                pf     = out_flit;
                pbusy  = busy;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t0;
        for (int p = 0; p < P; p++) begin
            hold[p] = 0;
            sent[p] = 0;
        end
        #1 rst = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_proto, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Round robin: 3-flit packets from all ports, 4 cycles per packet.
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < P; p++) add_pkt(p, 3, 16'hA000 + 16'(p * 16), 0);
        c0 = xfer_cnt;
        go(4'hF);
        for (int i = 0; i < 50 && xfer_cnt == c0; i++) tick();
        t0 = last_xfer;
        drain("rr_drain");
        chk("rr_span", 32'(last_xfer - t0), 32'd46);

        // Backpressure with out_ready pattern 1,0,0.
        or_mode = 1;
        add_pkt(1, 5, 16'h5100, 0);
        go(4'hF);
        drain("bp_drain");
        or_mode = 0;

        // Randomized packets, enables and backpressure.
        or_mode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < P; p++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 5), 16'h0, 1);
            end
            go(4'($urandom_range(1, 15)));
            drain("rand_drain");
        end
        go(4'hF);
        drain("rand_flush");
        or_mode = 0;

        // Enable mask: only ports 0 and 2 served.
        for (int p = 0; p < P; p++)
            for (int k = 0; k < 3; k++) add_pkt(p, 1, 16'hE000 + 16'(p * 16 + k), 0);
        go(4'b0101);
        drain("mask_drain");
        add_pkt(2, 3, 16'hE200, 0);
        go(4'b0101);
        for (int i = 0; i < 20 && !(busy && grant == 2'd2); i++) tick();
        chk("mask_lock2", 32'(busy && grant == 2'd2), 32'd1);
        cfg_enable = 4'b0001;
        drain("mask_midpkt");
        add_pkt(2, 1, 16'hE2F0, 0);
        go(4'b0001);
        for (int i = 0; i < 8; i++) tick();
        chk("mask_blocked", busy, 0);
        go(4'hF);
        drain("mask_flush");

        // Protocol error: header, payload, header, tail on port 3.
        chk("err_pre", err_proto, 0);
        sent[3] = 0;
        put(3, 2'b01, 16'hD300);
        put(3, 2'b00, 16'hD301);
        put(3, 2'b01, 16'hD302);
        put(3, 2'b10, 16'hD303);
        go(4'hF);
        for (int i = 0; i < 50 && sent[3] < 2; i++) tick();
        chk("err_before_hdr2", err_proto, 0);
        for (int i = 0; i < 50 && sent[3] < 3; i++) tick();
        chk("err_after_hdr2", err_proto, 1);
        drain("proto_drain");

        // Wrap-around: port 0 header appears as port 3's tail transfers.
        hold[0] = 1;
        add_pkt(3, 3, 16'hB030, 0);
        add_pkt(0, 3, 16'hB000, 0);
        take(3);
        take(0);
        mdl_rr   = 1;
        wrap_arm = 1;
        present();
        for (int i = 0; i < 50 && hold[0]; i++) tick();
        chk("wrap_armed", 32'(hold[0]), 0);
        tick();
        chk("wrap_idle_cycle", busy, 0);
        tick();
        chk("wrap_busy", busy, 1);
        chk("wrap_grant", grant, 0);
        chk("wrap_rr_ptr", u_dut.rr_ptr, 0);
        drain("wrap_drain");

        // Reset in the middle of a 5-flit packet on port 2.
        sent[2] = 0;
        add_pkt(2, 5, 16'hC020, 0);
        go(4'hF);
        for (int i = 0; i < 50 && sent[2] < 2; i++) tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_flit", out_flit, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_grant", grant, 0);
        chk("arst_err", err_proto, 0);
        mdl_rr = 0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_err_early", err_proto, 0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_err_set", err_proto, 1);
        chk("stall_not_granted", busy, 0);
        pq[2].delete();
        present();
        rst = 1'b0;
        #1;
        chk("err_cleared", err_proto, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
